// File: rtl/handshake_rr_arbiter_if.sv
// Bundle for the round-robin handshake arbiter: N producer channels in, one tagged stream out.
//
// Handshake: a beat moves on a channel at a rising clk edge where that channel's valid and
// ready are both high. A producer keeps valid and data stable until the beat is taken. Ready
// may depend combinationally on valid, but valid never waits on ready.
interface handshake_rr_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CHANNEL = 2
);
    localparam int ChannelWidth = (NUM_CHANNEL >= 2) ? $clog2(NUM_CHANNEL) : 1;

    logic [NUM_CHANNEL*DATA_WIDTH-1:0] in_data;
    logic [NUM_CHANNEL-1:0]            in_valid;
    logic [NUM_CHANNEL-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]             out_data;
    logic [ChannelWidth-1:0]           out_channel;
    logic                              out_valid;
    logic                              out_ready;
    // Observation of the skid stage as {main_valid, skid_valid}.
    logic [1:0]                        skid_state;

    // master: the arbiter itself; slave: the producers and the consumer around it.
    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_channel, out_valid, skid_state
    );
    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_channel, out_valid, skid_state
    );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin merge of NUM_CHANNEL ready/valid producers into one stream, with a
// registered two-entry skid stage so out_valid/out_data come straight from flops.
module handshake_rr_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CHANNEL = 2
) (
    input logic                    clk,
    input logic                    rst,
    handshake_rr_arbiter_if.master bus
);
    localparam int ChannelWidth = (NUM_CHANNEL >= 2) ? $clog2(NUM_CHANNEL) : 1;

    // Skid stage states, encoded as {main_valid, skid_valid}; 2'b01 is unreachable.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] FULL1 = 2'b10;
    localparam logic [1:0] FULL2 = 2'b11;

    logic [ChannelWidth-1:0] rr_ptr;
    logic [ChannelWidth-1:0] next_ptr;
    logic [ChannelWidth-1:0] grant_idx;
    logic [NUM_CHANNEL-1:0]  grant;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic                    any_valid;
    logic                    accept;

    logic                    main_valid;
    logic                    skid_valid;
    logic [DATA_WIDTH-1:0]   main_data;
    logic [DATA_WIDTH-1:0]   skid_data;
    logic [ChannelWidth-1:0] main_channel;
    logic [ChannelWidth-1:0] skid_channel;

    // Pick the valid channel closest to rr_ptr going upward with wrap, and mux its payload.
    always_comb begin
        int best_off;
        int off;
        best_off   = NUM_CHANNEL;
        off        = 0;
        grant_idx  = '0;
        grant      = '0;
        grant_data = '0;
        any_valid  = |bus.in_valid;
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            off = c - int'(rr_ptr);
            if (off < 0) off = off + NUM_CHANNEL;
            if (bus.in_valid[c] && (off < best_off)) begin
                best_off  = off;
                grant_idx = ChannelWidth'(c);
            end
        end
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            if (any_valid && (int'(grant_idx) == c)) begin
                grant[c]   = 1'b1;
                grant_data = bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointer advances past the channel just served; a single channel always wraps to 0.
    assign next_ptr = (grant_idx == ChannelWidth'(NUM_CHANNEL - 1)) ? '0 : grant_idx + 1'b1;

    // Nothing is offered while the skid entry is occupied or reset is held.
    assign bus.in_ready = grant & {NUM_CHANNEL{!skid_valid && !rst}};
    assign accept       = any_valid && !skid_valid && !rst;

    assign bus.out_valid   = main_valid;
    assign bus.out_data    = main_data;
    assign bus.out_channel = main_channel;
    assign bus.skid_state  = {main_valid, skid_valid};

    // Round-robin pointer: moves only when a beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= next_ptr;
        end
    end

    // Skid stage: main holds the head beat, skid catches one beat taken during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid   <= 1'b0;
            skid_valid   <= 1'b0;
            main_data    <= '0;
            main_channel <= '0;
            skid_data    <= '0;
            skid_channel <= '0;
        end else begin
            case ({main_valid, skid_valid})
                EMPTY: begin
                    if (accept) begin
                        main_valid   <= 1'b1;
                        main_data    <= grant_data;
                        main_channel <= grant_idx;
                    end
                end
                FULL1: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            main_data    <= grant_data;
                            main_channel <= grant_idx;
                        end else begin
                            main_valid <= 1'b0;
                        end
                    end else if (accept) begin
                        skid_valid   <= 1'b1;
                        skid_data    <= grant_data;
                        skid_channel <= grant_idx;
                    end
                end
                FULL2: begin
                    if (bus.out_ready) begin
                        main_data    <= skid_data;
                        main_channel <= skid_channel;
                        skid_valid   <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: drop the orphan skid entry.
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed and scoreboarded checks of handshake_rr_arbiter with 4 channels, plus a
// single-channel instance exercised as a full-rate pass-through.
module tb_handshake_rr_arbiter;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int QW = CW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    handshake_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_CHANNEL(NC)) bus ();
    handshake_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_CHANNEL(1))  bus1 ();

    handshake_rr_arbiter #(.DATA_WIDTH(DW), .NUM_CHANNEL(NC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    handshake_rr_arbiter #(.DATA_WIDTH(DW), .NUM_CHANNEL(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int vec_count = 0;
    int err_count = 0;
    logic [QW-1:0] exp_q[$];

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_all_data();
        for (int i = 0; i < NC; i++) bus.in_data[i*DW +: DW] = 32'hA0 + 32'(i);
    endtask

    task automatic set_ch_data(input int ch, input logic [DW-1:0] d);
        bus.in_data[ch*DW +: DW] = d;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NC-1:0]   pend;
        logic [DW-1:0]   pdata[NC];
        logic [23:0]     seq;
        logic            held;
        logic [QW-1:0]   held_beat;
        logic [QW-1:0]   beat;
        logic [NC-1:0]   acc;
        logic [NC-1:0]   exp_rdy;

        bus.in_valid   = '0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = '0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;

        // 1. Reset with every channel requesting
        bus.in_valid = 4'hF;
        set_all_data();
        tick();
        tick();
        settle();
        check("rst_in_ready",  bus.in_ready,   4'b0000);
        check("rst_out_valid", bus.out_valid,  1'b0);
        check("rst_out_data",  bus.out_data,   32'h0);
        check("rst_out_chan",  bus.out_channel, 2'd0);
        check("rst_state",     bus.skid_state, 2'b00);
        rst = 1'b0;
        settle();
        check("rel_in_ready", bus.in_ready, 4'b0001);
        tick();
        check("rel_out_valid", bus.out_valid, 1'b1);
        check("rel_out_chan",  bus.out_channel, 2'd0);
        check("rel_out_data",  bus.out_data, 32'hA0);

        // 2. Fairness: continuous requests rotate 1,2,3,0,... one beat per cycle
        for (int i = 1; i <= 10; i++) begin
            exp_rdy = 4'b0001 << (i % 4);
            settle();
            check("fair_in_ready", bus.in_ready, exp_rdy);
            tick();
            check("fair_out_valid", bus.out_valid, 1'b1);
            check("fair_out_chan", bus.out_channel, 64'(i % 4));
            check("fair_out_data", bus.out_data, 64'(32'hA0 + i % 4));
        end

        // 3. Sparse: rr_ptr is now 3, only ch2 requests -> wrap scan picks ch2
        bus.in_valid = 4'b0100;
        set_ch_data(2, 32'h55);
        settle();
        check("sparse_in_ready", bus.in_ready, 4'b0100);
        tick();
        check("sparse_out_chan", bus.out_channel, 2'd2);
        check("sparse_out_data", bus.out_data, 32'h55);
        bus.in_valid = 4'hF;
        set_all_data();
        settle();
        check("sparse_ptr3", bus.in_ready, 4'b1000);
        bus.in_valid = 4'b0000;
        settle();
        check("idle_in_ready", bus.in_ready, 4'b0000);
        tick();
        check("idle_out_valid", bus.out_valid, 1'b0);

        // 4. Backpressure on a ch1 stream 1,2,3 with out_ready low for 3 cycles
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0010;
        set_ch_data(1, 32'd1);
        settle();
        check("bp_rdy1", bus.in_ready, 4'b0010);
        tick();
        check("bp_out1", bus.out_data, 32'd1);
        check("bp_chan", bus.out_channel, 2'd1);
        check("bp_state1", bus.skid_state, 2'b10);
        set_ch_data(1, 32'd2);
        settle();
        check("bp_rdy2", bus.in_ready, 4'b0010);
        tick();
        check("bp_state2", bus.skid_state, 2'b11);
        check("bp_hold1", bus.out_data, 32'd1);
        set_ch_data(1, 32'd3);
        settle();
        check("bp_rdy_full", bus.in_ready, 4'b0000);
        tick();
        check("bp_hold2", bus.out_data, 32'd1);
        check("bp_state3", bus.skid_state, 2'b11);
        bus.out_ready = 1'b1;
        settle();
        check("bp_rdy_drain", bus.in_ready, 4'b0000);
        tick();
        check("bp_out2", bus.out_data, 32'd2);
        check("bp_state4", bus.skid_state, 2'b10);
        settle();
        check("bp_rdy3", bus.in_ready, 4'b0010);
        tick();
        check("bp_out3", bus.out_data, 32'd3);
        check("bp_chan3", bus.out_channel, 2'd1);
        bus.in_valid = 4'b0000;
        tick();
        check("bp_empty", bus.out_valid, 1'b0);

        // 6. Reset while FULL2; rr_ptr is 2 so ch0 is found by wrapping
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0001;
        set_ch_data(0, 32'h11);
        settle();
        check("mr_rdy1", bus.in_ready, 4'b0001);
        tick();
        check("mr_out1", bus.out_data, 32'h11);
        set_ch_data(0, 32'h12);
        settle();
        check("mr_rdy2", bus.in_ready, 4'b0001);
        tick();
        check("mr_full2", bus.skid_state, 2'b11);
        rst = 1'b1;
        settle();
        check("mr_out_valid", bus.out_valid, 1'b0);
        check("mr_in_ready", bus.in_ready, 4'b0000);
        check("mr_out_data", bus.out_data, 32'h0);
        check("mr_state", bus.skid_state, 2'b00);
        tick();
        tick();
        rst = 1'b0;
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        tick();
        check("mr_no_stale", bus.out_valid, 1'b0);
        bus.in_valid = 4'hF;
        set_all_data();
        settle();
        check("mr_ptr0", bus.in_ready, 4'b0001);
        bus.in_valid = 4'b0000;
        tick();

        // 5. Random traffic against the expected queue
        pend = '0;
        seq  = '0;
        held = 1'b0;
        held_beat = '0;
        for (int c = 0; c < NC; c++) pdata[c] = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                if (!pend[c] && ($urandom_range(0, 99) < 55)) begin
                    pend[c]  = 1'b1;
                    pdata[c] = {8'(c), seq};
                    seq++;
                end
                bus.in_data[c*DW +: DW] = pdata[c];
            end
            bus.in_valid  = pend;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            settle();
            check("rnd_ready_legal",
                  64'(((bus.in_ready & ~bus.in_valid) == '0) && $onehot0(bus.in_ready)), 64'd1);
            if (held) check("rnd_stall_stable", {bus.out_valid, bus.out_channel, bus.out_data},
                            {1'b1, held_beat});
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    beat = exp_q.pop_front();
                    check("rnd_beat", {bus.out_channel, bus.out_data}, beat);
                end
            end
            held      = bus.out_valid && !bus.out_ready;
            held_beat = {bus.out_channel, bus.out_data};
            acc       = bus.in_ready & bus.in_valid;
            for (int c = 0; c < NC; c++) begin
                if (acc[c]) begin
                    exp_q.push_back({CW'(c), pdata[c]});
                    pend[c] = 1'b0;
                end
            end
            tick();
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            settle();
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    beat = exp_q.pop_front();
                    check("drain_beat", {bus.out_channel, bus.out_data}, beat);
                end
            end
            tick();
        end
        check("rnd_drained", 64'(exp_q.size()), 64'd0);

        // Single channel: pass-through at one beat per cycle
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 32'h100;
        for (int k = 0; k < 6; k++) begin
            settle();
            check("one_in_ready", bus1.in_ready, 1'b1);
            tick();
            check("one_out_valid", bus1.out_valid, 1'b1);
            check("one_out_data", bus1.out_data, 64'(32'h100 + k));
            check("one_out_chan", bus1.out_channel, 1'b0);
            bus1.in_data = bus1.in_data + 32'd1;
        end
        bus1.in_valid = 1'b0;
        tick();
        check("one_idle", bus1.out_valid, 1'b0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule
